if_fetch_unit: RTL and testbench

Instruction-fetch stage of the pipelined CPU, and the producer that drives the IF/ID pipeline register. It owns the fetch PC and issues addresses to a synchronous instruction memory with one-cycle read latency. It presents each (PC, instruction, valid) triple on registered outputs to the ID stage. It absorbs hazard-unit stalls through a one-entry skid buffer, so no fetched instruction is lost, and it handles branch redirects by squashing wrong-path work.

---
 rtl/if_fetch_unit_if.sv | 23 ++
 rtl/if_fetch_unit.sv | 138 +++++++++++++
 tb/tb_if_fetch_unit.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/if_fetch_unit_if.sv
// Fetch-stage bus: hazard/branch controls from the pipeline, the instruction-memory
// request/response pair, and the registered (PC, instruction, valid) triple toward ID.
interface if_fetch_unit_if;
  logic        stall;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic        imem_en;
  logic [63:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [63:0] PC_out;
  logic [31:0] instr_out;
  logic        valid_out;

  modport master (
    input  stall, redirect, redirect_pc, imem_rdata,
    output imem_en, imem_addr, PC_out, instr_out, valid_out
  );

  modport slave (
    output stall, redirect, redirect_pc, imem_rdata,
    input  imem_en, imem_addr, PC_out, instr_out, valid_out
  );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction fetch: issue-to-output latency 2 cycles, 1 instr/cycle; stall holds outputs and parks
// the in-flight response in a one-entry skid. IF_PERF_CTR_EN adds fetch_count/bubble_count ports.
module if_fetch_unit #(
  parameter logic [63:0] RESET_PC  = 64'd0,
  parameter logic [31:0] NOP_INSTR = 32'hD503201F
) (
  input  logic         clk,
  input  logic         reset,
  if_fetch_unit_if.master bus
`ifdef IF_PERF_CTR_EN
  ,
  output logic [31:0]  fetch_count,
  output logic [31:0]  bubble_count
`endif
);

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
  } fetch_dat_t;

  // Encoding is {inflight_v, skid_v}; both set at once cannot arise.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    HOLD = 2'b01,
    RUN  = 2'b10
  } state_t;

  state_t      state_q, state_d;
  logic [63:0] fpc_q, fpc_d;
  logic [63:0] inflight_pc_q, inflight_pc_d;
  fetch_dat_t  skid_q, skid_d;
  fetch_dat_t  out_q, out_d;
  logic        valid_q, valid_d;

  logic        inflight_v;
  logic        skid_v;
  logic        skid_v_d;
  logic        imem_en;
  logic [63:0] imem_addr;
  fetch_dat_t  rsp;

  assign inflight_v = state_q[1];
  assign skid_v     = state_q[0];

  assign imem_en   = !reset && (!bus.stall || bus.redirect);
  assign imem_addr = bus.redirect ? (bus.redirect_pc & ~64'h3) : fpc_q;
  assign rsp       = {inflight_pc_q, bus.imem_rdata};

  always_comb begin
    fpc_d         = fpc_q;
    inflight_pc_d = inflight_pc_q;
    skid_d        = skid_q;
    out_d         = out_q;
    valid_d       = valid_q;
    skid_v_d      = skid_v;
    state_d       = state_q;

    if (imem_en) begin
      fpc_d         = imem_addr + 64'd4;
      inflight_pc_d = imem_addr;
    end

    if (bus.redirect) begin
      valid_d     = 1'b0;
      out_d.instr = NOP_INSTR;
      skid_v_d    = 1'b0;
    end else if (bus.stall) begin
      if (inflight_v) begin
        skid_v_d = 1'b1;
        skid_d   = rsp;
      end
    end else if (skid_v) begin
      out_d    = skid_q;
      valid_d  = 1'b1;
      skid_v_d = 1'b0;
    end else if (inflight_v) begin
      out_d   = rsp;
      valid_d = 1'b1;
    end else begin
      valid_d     = 1'b0;
      out_d.instr = NOP_INSTR;
    end

    case ({imem_en, skid_v_d})
      2'b10:   state_d = RUN;
      2'b01:   state_d = HOLD;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      fpc_q         <= RESET_PC;
      inflight_pc_q <= 64'd0;
      skid_q        <= '0;
      out_q         <= {64'd0, NOP_INSTR};
      valid_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      fpc_q         <= fpc_d;
      inflight_pc_q <= inflight_pc_d;
      skid_q        <= skid_d;
      out_q         <= out_d;
      valid_q       <= valid_d;
    end
  end

  assign bus.imem_en   = imem_en;
  assign bus.imem_addr = imem_addr;
  assign bus.PC_out    = out_q.pc;
  assign bus.instr_out = out_q.instr;
  assign bus.valid_out = valid_q;

`ifdef IF_PERF_CTR_EN
  logic [31:0] fetch_cnt_q;
  logic [31:0] bubble_cnt_q;
  logic        load_bubble;

  // Mirrors the two bubble-loading branches of the output update.
  assign load_bubble = bus.redirect || (!bus.stall && !skid_v && !inflight_v);

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_cnt_q  <= 32'd0;
      bubble_cnt_q <= 32'd0;
    end else begin
      if (imem_en)     fetch_cnt_q  <= fetch_cnt_q + 32'd1;
      if (load_bubble) bubble_cnt_q <= bubble_cnt_q + 32'd1;
    end
  end

  assign fetch_count  = fetch_cnt_q;
  assign bubble_count = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit against a one-cycle memory returning addr+0x1000.
module tb_if_fetch_unit;
  localparam logic [31:0] NOP = 32'hD503201F;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  if_fetch_unit_if bus ();

`ifdef IF_PERF_CTR_EN
  logic [31:0] fetch_count;
  logic [31:0] bubble_count;
`endif

  if_fetch_unit dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus)
`ifdef IF_PERF_CTR_EN
    ,
    .fetch_count  (fetch_count),
    .bubble_count (bubble_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.imem_en) bus.imem_rdata <= bus.imem_addr[31:0] + 32'h1000;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic v, input logic [63:0] pc,
                            input logic [31:0] instr);
    check({tag, "_valid"}, {63'd0, bus.valid_out}, {63'd0, v});
    check({tag, "_pc"},    bus.PC_out, pc);
    check({tag, "_instr"}, {32'd0, bus.instr_out}, {32'd0, instr});
  endtask

  task automatic expect_issue(input string tag, input logic en, input logic [63:0] addr);
    check({tag, "_en"}, {63'd0, bus.imem_en}, {63'd0, en});
    if (en) check({tag, "_addr"}, bus.imem_addr, addr);
  endtask

  task automatic drive(input logic s, input logic r, input logic [63:0] rpc);
    bus.stall       = s;
    bus.redirect    = r;
    bus.redirect_pc = rpc;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!reset) check("fsm_legal", {63'd0, (dut.state_q == 2'b11)}, 64'd0);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, required completion");
    $fatal(1);
  end

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    drive(1'b0, 1'b0, 64'd0);
    step();
    step();
    expect_out("reset", 1'b0, 64'd0, NOP);
    expect_issue("reset_en", 1'b0, 64'd0);
`ifdef IF_PERF_CTR_EN
    check("reset_fetch_cnt", {32'd0, fetch_count}, 64'd0);
    check("reset_bubble_cnt", {32'd0, bubble_count}, 64'd0);
`endif

    // Cycle 0: first issue of RESET_PC.
    reset = 1'b0;
    #1;
    expect_issue("c0", 1'b1, 64'h0);
    step();
    expect_out("c1_bubble", 1'b0, 64'd0, NOP);
    expect_issue("c1", 1'b1, 64'h4);
    for (int k = 2; k <= 6; k++) begin
      step();
      expect_out("run", 1'b1, 64'((k - 2) * 4), 32'((k - 2) * 4 + 32'h1000));
`ifdef IF_PERF_CTR_EN
      if (k == 2) begin
        check("c2_fetch_cnt", {32'd0, fetch_count}, 64'd2);
        check("c2_bubble_cnt", {32'd0, bubble_count}, 64'd1);
      end
`endif
    end

    // Stall cycles 6..8 while PC 0x10 is presented; release in cycle 9.
    drive(1'b1, 1'b0, 64'd0);
    expect_issue("stall_c6", 1'b0, 64'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      expect_out("stall_hold", 1'b1, 64'h10, 32'h1010);
      if (i < 2) begin
        expect_issue("stall_en", 1'b0, 64'd0);
      end else begin
        drive(1'b0, 1'b0, 64'd0);
        expect_issue("release", 1'b1, 64'h18);
      end
    end
    step();
    expect_out("skid_out", 1'b1, 64'h14, 32'h1014);
    step();
    expect_out("post_skid", 1'b1, 64'h18, 32'h1018);
    step();
    expect_out("post_skid2", 1'b1, 64'h1C, 32'h101C);

    // Redirect to unaligned 0x203 in cycle 12.
    drive(1'b0, 1'b1, 64'h203);
    expect_issue("redir", 1'b1, 64'h200);
    step();
    expect_out("redir_bubble", 1'b0, 64'h1C, NOP);
    drive(1'b0, 1'b0, 64'd0);
    expect_issue("redir_next", 1'b1, 64'h204);
    step();
    expect_out("redir_tgt", 1'b1, 64'h200, 32'h1200);
    step();
    expect_out("redir_tgt2", 1'b1, 64'h204, 32'h1204);

    // Fill the skid, then redirect with stall held.
    drive(1'b1, 1'b0, 64'd0);
    step();
    expect_out("skid_full_hold", 1'b1, 64'h204, 32'h1204);
    drive(1'b1, 1'b1, 64'h400);
    expect_issue("redir_stall", 1'b1, 64'h400);
    step();
    expect_out("redir_stall_bubble", 1'b0, 64'h204, NOP);
    drive(1'b0, 1'b0, 64'd0);
    step();
    expect_out("redir_stall_tgt", 1'b1, 64'h400, 32'h1400);
    step();
    expect_out("redir_stall_tgt2", 1'b1, 64'h404, 32'h1404);

    // Redirect to the top of the address space: fetch PC wraps.
    drive(1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
    expect_issue("wrap_redir", 1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
    step();
    expect_out("wrap_bubble", 1'b0, 64'h404, NOP);
    drive(1'b0, 1'b0, 64'd0);
    expect_issue("wrap_fpc", 1'b1, 64'h0);
    step();
    expect_out("wrap_top", 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 32'h0000_0FFC);
    step();
    expect_out("wrap_zero", 1'b1, 64'h0, 32'h1000);

    // Back-to-back redirects: the second one wins.
    drive(1'b0, 1'b1, 64'h800);
    step();
    expect_out("b2b_bubble1", 1'b0, 64'h0, NOP);
    drive(1'b0, 1'b1, 64'h900);
    expect_issue("b2b_second", 1'b1, 64'h900);
    step();
    expect_out("b2b_bubble2", 1'b0, 64'h0, NOP);
    drive(1'b0, 1'b0, 64'd0);
    step();
    expect_out("b2b_tgt", 1'b1, 64'h900, 32'h1900);

    // Reset while stalled with the skid full.
    drive(1'b1, 1'b0, 64'd0);
    step();
    expect_out("pre_rst_hold", 1'b1, 64'h900, 32'h1900);
    reset = 1'b1;
    #1;
    expect_issue("rst_en", 1'b0, 64'd0);
    step();
    expect_out("mid_rst", 1'b0, 64'd0, NOP);
`ifdef IF_PERF_CTR_EN
    check("mid_rst_fetch_cnt", {32'd0, fetch_count}, 64'd0);
    check("mid_rst_bubble_cnt", {32'd0, bubble_count}, 64'd0);
`endif
    reset = 1'b0;
    drive(1'b0, 1'b0, 64'd0);
    expect_issue("restart", 1'b1, 64'h0);
    step();
    expect_out("restart_bubble", 1'b0, 64'd0, NOP);
    step();
    expect_out("restart_c2", 1'b1, 64'h0, 32'h1000);
    step();
    expect_out("restart_c3", 1'b1, 64'h4, 32'h1004);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
